// File: rtl/seq_feeder_if.sv
// Request/FIFO-write bundle between the job requesters, the feeder and the call FIFO.
//
// Handshake: req is a one-cycle pulse per job and needs no acknowledge to be
// captured. full is a level sampled only while the feeder is idle. A FIFO write
// is the rising edge of clk_f. data_f is already stable one full clk cycle before
// that edge and stays stable through it. ack[i] pulses for one cycle once job i's
// write is complete.
interface seq_feeder_if #(
  parameter int n    = 5,
  parameter int jobs = 4
);
  logic [jobs-1:0] req;
  logic            full;
  logic [n-1:0]    data_f;
  logic            clk_f;
  logic [jobs-1:0] ack;
  logic [jobs-1:0] pend;
  logic            ovf;
  logic [1:0]      state_dbg;

  // The feeder drives the FIFO write side.
  modport master (
    input  req, full,
    output data_f, clk_f, ack, pend, ovf, state_dbg
  );

  // Requesters and FIFO status drive the inputs and observe the outputs.
  modport slave (
    output req, full,
    input  data_f, clk_f, ack, pend, ovf, state_dbg
  );
endinterface

// File: rtl/seq_feeder.sv
// Sequencer call-FIFO write-side producer.
// Per-job sticky pending bits feed a round-robin arbiter. Each granted job
// becomes one FIFO write of its program entry address. A write takes three
// cycles: present the data, raise the strobe, then drop the strobe and acknowledge.
module seq_feeder #(
  parameter int n    = 5,
  parameter int jobs = 4,
  parameter logic [jobs*n-1:0] entries = {5'd25, 5'd19, 5'd12, 5'd2}
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_feeder_if.master bus
);

  localparam int PW = (jobs > 1) ? $clog2(jobs) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [jobs-1:0] pend_q, pend_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [n-1:0]    data_q, data_d;
  logic            clk_f_q, clk_f_d;
  logic [jobs-1:0] ack_q, ack_d;
  logic            ovf_q, ovf_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic [jobs-1:0] clr;

  // Round-robin search: first pending slot at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < jobs; i++) begin
      idx = PW'((int'(ptr_q) + i) % jobs);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state for the write FSM, pending bits and the overflow flag.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    clk_f_d = clk_f_q;
    ack_d   = '0;
    clr     = '0;

    case (state_q)
      IDLE: begin
        // full is only consulted here; a committed write always completes.
        if (found && !bus.full) begin
          sel_d   = pick;
          data_d  = entries[int'(pick)*n +: n];
          state_d = SETUP;
        end
      end
      SETUP: begin
        clk_f_d = 1'b1;
        state_d = STROBE;
      end
      STROBE: begin
        clk_f_d    = 1'b0;
        clr[sel_q] = 1'b1;
        ack_d      = clr;
        ptr_d      = (int'(sel_q) == jobs - 1) ? '0 : sel_q + 1'b1;
        state_d    = IDLE;
      end
      default: begin
        clk_f_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A new request on the clearing edge re-arms the slot without counting as a merge.
    ovf_d  = |(bus.req & pend_q & ~clr);
    pend_d = (pend_q & ~clr) | bus.req;
  end

  // All state and outputs are registered; reset drops the strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      clk_f_q <= 1'b0;
      ack_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      clk_f_q <= clk_f_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.data_f    = data_q;
  assign bus.clk_f     = clk_f_q;
  assign bus.ack       = ack_q;
  assign bus.pend      = pend_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seq_feeder.sv
// Bench for seq_feeder: directed scenarios plus random traffic.
// A cycle-level reference model predicts every output, and a FIFO-side
// scoreboard checks each strobed write against an expected queue.
module tb_seq_feeder;

  logic clk;
  logic rst_n;

  seq_feeder_if #(.n(5), .jobs(4)) bus ();

  seq_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          entry_tab [4] = '{2, 12, 19, 25};
  logic [3:0]  m_pend;
  int          m_ptr, m_sel, m_phase;
  logic [4:0]  m_data;
  logic        m_clkf, m_ovf;
  logic [3:0]  m_ack;
  logic [4:0]  exp_q [$];

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_sel = 0; m_phase = 0;
    m_data = '0; m_clkf = 1'b0; m_ovf = 1'b0; m_ack = '0;
  endtask

  initial model_reset();

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge clk) begin
    logic [3:0] r, clr;
    logic       f;
    int         s;
    if (!rst_n) begin
      model_reset();
    end else begin
      r = bus.req; f = bus.full; clr = '0;
      m_ack = '0; m_ovf = 1'b0;
      if (m_phase == 0) begin
        if (m_pend != 0 && !f) begin
          for (int i = 0; i < 4; i++) begin
            s = (m_ptr + i) % 4;
            if (m_pend[s]) begin
              m_sel = s;
              break;
            end
          end
          m_data  = 5'(entry_tab[m_sel]);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_clkf  = 1'b1;
        exp_q.push_back(m_data);
        m_phase = 2;
      end else begin
        m_clkf        = 1'b0;
        clr[m_sel]    = 1'b1;
        m_ack         = clr;
        m_ptr         = (m_sel + 1) % 4;
        m_phase       = 0;
      end
      for (int i = 0; i < 4; i++)
        if (r[i] && m_pend[i] && !clr[i]) m_ovf = 1'b1;
      m_pend = (m_pend & ~clr) | r;
    end
    #1;
    if (rst_n) begin
      chk("data_f", 32'(bus.data_f), 32'(m_data));
      chk("clk_f",  32'(bus.clk_f),  32'(m_clkf));
      chk("ack",    32'(bus.ack),    32'(m_ack));
      chk("pend",   32'(bus.pend),   32'(m_pend));
      chk("ovf",    32'(bus.ovf),    32'(m_ovf));
    end
  end

  // ---------------- FIFO-side scoreboard ----------------
  int got_q [$];
  int got_cyc [$];
  int ovf_cnt = 0;

  always @(posedge bus.clk_f) begin
    got_q.push_back(int'(bus.data_f));
    got_cyc.push_back(cyc);
    if (exp_q.size() == 0) begin
      chk("fifo_unexpected_write", 32'(bus.data_f), 32'hFFFF_FFFF);
    end else begin
      chk("fifo_write", 32'(bus.data_f), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) if (rst_n && bus.ovf) ovf_cnt++;

  // ---------------- driver tasks ----------------
  task automatic nclk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.req = '0; bus.full = 1'b0;
    nclk(2);
    rst_n = 1'b1;
    nclk(1);
    got_q.delete(); got_cyc.delete(); ovf_cnt = 0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    @(negedge clk);
    bus.req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; bus.req = '0; bus.full = 1'b0;
    nclk(2);
    chk("rst_data_f", 32'(bus.data_f), 0);
    chk("rst_clk_f",  32'(bus.clk_f),  0);
    chk("rst_pend",   32'(bus.pend),   0);
    chk("rst_ack",    32'(bus.ack),    0);
    chk("rst_ovf",    32'(bus.ovf),    0);
    rst_n = 1'b1;
    nclk(2);

    // Single job on slot 1: data at k+1, strobe at k+2, ack at k+3.
    pulse_req(4'b0010);                        // edge k has passed
    chk("single_pend_k", 32'(bus.pend), 32'b0010);
    nclk(1);
    chk("single_data_k1", 32'(bus.data_f), 12);
    chk("single_clkf_k1", 32'(bus.clk_f), 0);
    nclk(1);
    chk("single_clkf_k2", 32'(bus.clk_f), 1);
    nclk(1);
    chk("single_ack_k3",  32'(bus.ack), 32'b0010);
    chk("single_clkf_k3", 32'(bus.clk_f), 0);
    chk("single_pend_k3", 32'(bus.pend), 0);
    nclk(1);
    chk("single_ack_once", 32'(bus.ack), 0);

    // Reset during STROBE drops the strobe at once; the next write starts from slot 0.
    do_reset();
    pulse_req(4'b0001);
    nclk(2);
    chk("rst_mid_clkf_hi", 32'(bus.clk_f), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clkf", 32'(bus.clk_f), 0);
    chk("rst_mid_pend", 32'(bus.pend), 0);
    chk("rst_mid_ack",  32'(bus.ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nclk(1);
    chk("rst_release_ack", 32'(bus.ack), 0);
    chk("rst_release_ovf", 32'(bus.ovf), 0);
    got_q.delete(); got_cyc.delete();
    pulse_req(4'b1001);
    nclk(8);
    chk("rst_next_cnt",   32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("rst_next_first",  32'(got_q[0]), 2);
      chk("rst_next_second", 32'(got_q[1]), 25);
    end

    // Round-robin over all slots, then a wrapped pair.
    do_reset();
    pulse_req(4'b1111);
    nclk(14);
    chk("rr_cnt", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      chk("rr_w0", 32'(got_q[0]), 2);
      chk("rr_w1", 32'(got_q[1]), 12);
      chk("rr_w2", 32'(got_q[2]), 19);
      chk("rr_w3", 32'(got_q[3]), 25);
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 3);
    end
    got_q.delete(); got_cyc.delete();
    pulse_req(4'b0011);
    nclk(8);
    chk("rr_wrap_cnt", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("rr_wrap_w0", 32'(got_q[0]), 2);
      chk("rr_wrap_w1", 32'(got_q[1]), 12);
    end

    // Backpressure: nothing while full; full rising during SETUP does not abort.
    do_reset();
    @(negedge clk);
    bus.full = 1'b1;
    pulse_req(4'b0001);
    nclk(20);
    chk("full_no_write", 32'(got_q.size()), 0);
    chk("full_pend",     32'(bus.pend), 32'b0001);
    bus.full = 1'b0;
    nclk(1);
    chk("full_rel_data", 32'(bus.data_f), 2);
    chk("full_rel_clkf", 32'(bus.clk_f), 0);
    bus.full = 1'b1;                           // now in SETUP
    nclk(1);
    chk("full_setup_clkf", 32'(bus.clk_f), 1);
    nclk(1);
    chk("full_setup_ack",  32'(bus.ack), 32'b0001);
    chk("full_setup_pend", 32'(bus.pend), 0);
    bus.full = 1'b0;
    nclk(4);
    chk("full_write_cnt", 32'(got_q.size()), 1);

    // Merge: second request while pending -> one ovf, one write.
    do_reset();
    @(negedge clk);
    bus.full = 1'b1;
    pulse_req(4'b0100);
    pulse_req(4'b0100);
    chk("merge_ovf_now", 32'(bus.ovf), 1);
    bus.full = 1'b0;
    nclk(8);
    chk("merge_ovf_cnt",   32'(ovf_cnt), 1);
    chk("merge_write_cnt", 32'(got_q.size()), 1);
    if (got_q.size() == 1) chk("merge_write_val", 32'(got_q[0]), 19);

    // Request on the clearing edge: no ovf, second write of 19.
    got_q.delete(); got_cyc.delete(); ovf_cnt = 0;
    @(negedge clk);
    bus.req = 4'b0100;
    nclk(1);
    bus.req = '0;
    nclk(2);
    bus.req = 4'b0100;                         // seen on the STROBE exit edge
    nclk(1);
    bus.req = '0;
    chk("coinc_ack",  32'(bus.ack), 32'b0100);
    chk("coinc_pend", 32'(bus.pend), 32'b0100);
    chk("coinc_ovf",  32'(bus.ovf), 0);
    nclk(8);
    chk("coinc_ovf_cnt",   32'(ovf_cnt), 0);
    chk("coinc_write_cnt", 32'(got_q.size()), 2);
    if (got_q.size() == 2) chk("coinc_write_val", 32'(got_q[1]), 19);

    // Random traffic against the model and scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.full = ($urandom_range(0, 3) == 0);
      bus.req  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    end
    @(negedge clk);
    bus.req = '0; bus.full = 1'b0;
    nclk(20);
    chk("drain_pend",  32'(bus.pend), 0);
    chk("drain_exp_q", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
